// File: rtl/pattern_sequencer_pkg.sv
// pattern_sequencer_pkg: shared state/direction types and fade limits for the pattern sequencer
package pattern_sequencer_pkg;
  typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} state_t;
  typedef enum logic {DIR_NEXT, DIR_PREV} dir_t;
  localparam logic [1:0] FADE_MAX = 2'd3;
endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: control inputs and pattern/fade outputs of the sequencer
interface pattern_sequencer_if #(parameter int SEL_W = 2);
  logic vsync;
  logic paused;
  logic auto_en;
  logic next_req;
  logic prev_req;
  logic [SEL_W-1:0] pattern_sel;
  logic [1:0] fade_level;
  logic switch_pulse;
  logic busy;
  modport master (output vsync, paused, auto_en, next_req, prev_req,
                  input pattern_sel, fade_level, switch_pulse, busy);
  modport slave (input vsync, paused, auto_en, next_req, prev_req,
                 output pattern_sel, fade_level, switch_pulse, busy);
endinterface

// File: rtl/pattern_sequencer_edge_detect.sv
// edge_detect: single-cycle pulse on a rising or falling edge; IDLE is the reset level so no edge follows reset
module edge_detect #(
  parameter bit FALLING = 1'b0,
  parameter bit IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk) q <= rst ? IDLE : d;
  assign pulse = FALLING ? (q & ~d) : (d & ~q);
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-counted dwell/manual pattern stepping wrapped in fade-out, swap, fade-in
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS = 3,
  parameter int SEL_W = 2,
  parameter int DWELL_FRAMES = 300,
  parameter int FADE_STEP_FRAMES = 4
) (
  input logic clk,
  input logic rst,
  pattern_sequencer_if.slave bus
);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);
  state_t state, state_n;
  dir_t dir, dir_n, pend_dir, pend_dir_n;
  logic pend, pend_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [1:0] fade, fade_n;
  logic pulse, pulse_n;
  logic [15:0] dwell, dwell_n;
  logic [7:0] step, step_n;
  logic tick, next_edge, prev_edge, step_done;
  edge_detect #(.FALLING(1'b1), .IDLE(1'b1)) u_vsync (.clk(clk), .rst(rst), .d(bus.vsync), .pulse(tick));
  edge_detect #(.FALLING(1'b0), .IDLE(1'b1)) u_next (.clk(clk), .rst(rst), .d(bus.next_req), .pulse(next_edge));
  edge_detect #(.FALLING(1'b0), .IDLE(1'b1)) u_prev (.clk(clk), .rst(rst), .d(bus.prev_req), .pulse(prev_edge));
  assign step_done = step == STEP_LAST;
  always_ff @(posedge clk)
    if (rst) begin
      state <= SHOW;
      dir <= DIR_NEXT;
      pend_dir <= DIR_NEXT;
      pend <= 1'b0;
      sel <= '0;
      fade <= '0;
      pulse <= 1'b0;
      dwell <= '0;
      step <= '0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      pend_dir <= pend_dir_n;
      pend <= pend_n;
      sel <= sel_n;
      fade <= fade_n;
      pulse <= pulse_n;
      dwell <= dwell_n;
      step <= step_n;
    end
  always_comb begin
    state_n = state;
    dir_n = dir;
    pend_dir_n = pend_dir;
    pend_n = pend;
    sel_n = sel;
    fade_n = fade;
    pulse_n = 1'b0;
    dwell_n = dwell;
    step_n = step;
    if (state == SHOW && (next_edge || prev_edge)) begin
      pend_n = 1'b1;
      pend_dir_n = next_edge ? DIR_NEXT : DIR_PREV;
    end
    unique case (state)
      SHOW:
        if (tick) begin
          if (pend) begin
            state_n = FADE_OUT;
            dir_n = pend_dir;
          end else if (!bus.paused) begin
            if (dwell != DWELL_LAST) dwell_n = dwell + 16'd1;
            else if (bus.auto_en) begin
              state_n = FADE_OUT;
              dir_n = DIR_NEXT;
            end
          end
        end
      FADE_OUT:
        if (tick) begin
          step_n = step_done ? 8'd0 : step + 8'd1;
          if (step_done && fade == FADE_MAX) state_n = SWAP;
          else if (step_done) fade_n = fade + 2'd1;
        end
      SWAP: begin
        sel_n = (dir == DIR_NEXT) ? ((sel == SEL_LAST) ? '0 : sel + 1'b1)
                                  : ((sel == '0) ? SEL_LAST : sel - 1'b1);
        pulse_n = 1'b1;
        state_n = FADE_IN;
      end
      FADE_IN:
        if (tick) begin
          step_n = step_done ? 8'd0 : step + 8'd1;
          if (step_done && fade == 2'd0) begin
            state_n = SHOW;
            dwell_n = '0;
            pend_n = 1'b0;
          end else if (step_done) fade_n = fade - 2'd1;
        end
    endcase
  end
  assign bus.pattern_sel = sel;
  assign bus.fade_level = fade;
  assign bus.switch_pulse = pulse;
  assign bus.busy = state != SHOW;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed and random frame sequences checked against a tick-count reference model
module tb_pattern_sequencer;
  localparam int N = 3;
  localparam int D = 3;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  int pulses = 0;
  int ph = 0;
  int k = 0;
  int dwell = 0;
  int pend = 0;
  int dir = 1;
  int sel = 0;
  int changes = 0;
  logic nl = 1'b0;
  logic pl = 1'b0;
  pattern_sequencer_if #(.SEL_W(2)) bus ();
  pattern_sequencer #(.NUM_PATTERNS(N), .SEL_W(2), .DWELL_FRAMES(D), .FADE_STEP_FRAMES(S))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.switch_pulse === 1'b1) pulses++;
  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  function automatic int exp_fade();
    int l = (k / S > 3) ? 3 : k / S;
    return ph == 1 ? l : ph == 2 ? 3 - l : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_sel"}, 32'(bus.pattern_sel), sel);
    chk({tag, "_fade"}, 32'(bus.fade_level), exp_fade());
    chk({tag, "_busy"}, 32'(bus.busy), ph != 0);
    chk({tag, "_pulses"}, pulses, changes);
  endtask
  task automatic model_tick();
    if (ph == 0) begin
      if (pend != 0) begin
        ph = 1;
        k = 0;
        dir = pend;
      end else if (!bus.paused) begin
        if (dwell < D - 1) dwell++;
        else if (bus.auto_en) begin
          ph = 1;
          k = 0;
          dir = 1;
        end
      end
    end else begin
      k++;
      if (k == 4 * S && ph == 1) begin
        sel = (dir == 1) ? (sel + 1) % N : (sel + N - 1) % N;
        changes++;
        ph = 2;
        k = 0;
      end else if (k == 4 * S) begin
        ph = 0;
        k = 0;
        dwell = 0;
        pend = 0;
      end
    end
  endtask
  task automatic frame(input string tag);
    @(negedge clk);
    bus.vsync = 1'b0;
    model_tick();
    repeat (3) @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) frame(tag);
  endtask
  task automatic set_req(input logic n, input logic p);
    @(negedge clk);
    if (ph == 0) begin
      if (n && !nl) pend = 1;
      else if (p && !pl) pend = 2;
    end
    nl = n;
    pl = p;
    bus.next_req = n;
    bus.prev_req = p;
    @(negedge clk);
  endtask
  task automatic set_ctl(input logic pa, input logic ae);
    @(negedge clk);
    bus.paused = pa;
    bus.auto_en = ae;
  endtask
  initial begin
    int guard;
    int r;
    bus.vsync = 1'b1;
    bus.paused = 1'b0;
    bus.auto_en = 1'b0;
    bus.next_req = 1'b0;
    bus.prev_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_sel", 32'(bus.pattern_sel), 0);
    chk("reset_fade", 32'(bus.fade_level), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_pulse", 32'(bus.switch_pulse), 0);
    repeat (20) @(negedge clk);
    check_all("idle");
    set_ctl(1'b0, 1'b1);
    for (int t = 1; t <= 19; t++) begin
      frame("auto");
      if (t == 3) chk("t3_busy", 32'(bus.busy), 1);
      if (t == 5) chk("t5_fade", 32'(bus.fade_level), 1);
      if (t == 9) chk("t9_fade", 32'(bus.fade_level), 3);
      if (t == 11) chk("t11_sel", 32'(bus.pattern_sel), 1);
      if (t == 11) chk("t11_pulses", pulses, 1);
      if (t == 17) chk("t17_fade", 32'(bus.fade_level), 0);
      if (t == 19) chk("t19_busy", 32'(bus.busy), 0);
    end
    set_ctl(1'b0, 1'b0);
    set_req(1'b0, 1'b1);
    set_req(1'b0, 1'b0);
    frames(18, "prev_to0");
    set_req(1'b0, 1'b1);
    set_req(1'b0, 1'b0);
    frames(18, "wrap_prev");
    chk("wrap_prev_sel", 32'(bus.pattern_sel), 2);
    set_req(1'b1, 1'b0);
    set_req(1'b0, 1'b0);
    frames(18, "wrap_next");
    chk("wrap_next_sel", 32'(bus.pattern_sel), 0);
    set_ctl(1'b1, 1'b1);
    frames(10, "paused");
    set_req(1'b1, 1'b0);
    set_req(1'b0, 1'b0);
    frame("paused_req");
    chk("paused_req_busy", 32'(bus.busy), 1);
    frames(17, "paused_seq");
    set_ctl(1'b0, 1'b0);
    set_req(1'b1, 1'b0);
    set_req(1'b0, 1'b0);
    frames(12, "drop_pre");
    set_req(1'b1, 1'b0);
    set_req(1'b0, 1'b0);
    frames(8, "drop_post");
    set_req(1'b1, 1'b1);
    set_req(1'b0, 1'b0);
    frames(18, "both");
    set_req(1'b1, 1'b0);
    frames(20, "held");
    set_req(1'b0, 1'b0);
    frames(4, "held_rel");
    set_req(1'b1, 1'b0);
    set_req(1'b0, 1'b0);
    guard = 0;
    while (!(ph == 1 && exp_fade() == 2) && guard < 40) begin
      frame("to_fade2");
      guard++;
    end
    chk("fade2_reached", 32'(bus.fade_level), 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sel", 32'(bus.pattern_sel), 0);
    chk("midrst_fade", 32'(bus.fade_level), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_pulse", 32'(bus.switch_pulse), 0);
    rst = 1'b0;
    sel = 0;
    ph = 0;
    k = 0;
    dwell = 0;
    pend = 0;
    repeat (2) @(negedge clk);
    check_all("post_rst");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) frame("rand");
      else if (r < 8) set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else set_ctl(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
